// File: rtl/mips_pkg.sv
// Shared MIPS definitions: supported opcodes, instruction-loader state and
// error encodings. Used by the loader and the control decoder.
package mips_pkg;

  // Opcode field values (instr[31:26]) the single-cycle control decoder implements
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_DONE,
    ST_ERROR
  } loader_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_OPCODE   = 2'd1,
    ERR_ALIGN    = 2'd2,
    ERR_OVERFLOW = 2'd3
  } loader_err_t;

endpackage

// File: rtl/mips_opcode_check.sv
// Combinational opcode filter: flags whether a 6-bit opcode is one the
// control decoder supports.
module mips_opcode_check
  import mips_pkg::*;
(
  input  logic [5:0] i_opcode,
  output logic       o_supported
);

  // Membership test against the supported opcode set
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    o_supported = 1'b0;
    case (i_opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ,
      OP_ADDI, OP_J, OP_JAL: o_supported = 1'b1;
      default:               o_supported = 1'b0;
    endcase
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a host byte stream big-endian into 32-bit
// words, rejects unsupported opcodes and writes words sequentially from
// address 0. Optional running XOR checksum output under
// IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  output logic [ADDR_W:0]   words_loaded
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  // Word count at which memory is full; a further word is an overflow
  localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

  loader_state_t     r_state;
  loader_state_t     w_state_next;
  loader_err_t       r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [1:0]        r_byte_idx;
  logic              r_last;
  logic [ADDR_W:0]   r_words;
  logic              w_opcode_ok;
  logic              w_accept;
  logic              w_start_ok;
  logic              w_full;

  mips_opcode_check u_opcode_check (
    .i_opcode    (r_wdata[31:26]),
    .o_supported (w_opcode_ok)
  );

  // start only opens a session from an idle-like state; it is ignored while busy
  assign w_start_ok = start && (r_state == ST_IDLE || r_state == ST_DONE ||
                                r_state == ST_ERROR);
  assign w_accept   = in_valid && (r_state == ST_LOAD);
  assign w_full     = (r_words == CAPACITY);

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state decode and per-state strobes
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    imem_we      = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (w_start_ok) w_state_next = ST_LOAD;
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        if (w_accept) begin
          if (r_byte_idx == 2'd3) w_state_next = w_full ? ST_ERROR : ST_WRITE;
          else if (in_last)       w_state_next = ST_ERROR;
        end
      end
      ST_WRITE: begin
        if (w_opcode_ok) begin
          imem_we      = 1'b1;
          w_state_next = r_last ? ST_DONE : ST_LOAD;
        end else begin
          w_state_next = ST_ERROR;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Datapath: byte packing, address/count advance, sticky error capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err      <= ERR_NONE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_byte_idx <= '0;
      r_last     <= 1'b0;
      r_words    <= '0;
    end else if (w_start_ok) begin
      r_err      <= ERR_NONE;
      r_addr     <= '0;
      r_byte_idx <= '0;
      r_last     <= 1'b0;
      r_words    <= '0;
    end else if (w_accept) begin
      r_wdata    <= {r_wdata[23:0], in_data};
      r_byte_idx <= r_byte_idx + 2'd1;
      if (r_byte_idx == 2'd3) begin
        r_last <= in_last;
        if (w_full) r_err <= ERR_OVERFLOW;
      end else if (in_last) begin
        r_err <= ERR_ALIGN;
      end
    end else if (r_state == ST_WRITE) begin
      if (w_opcode_ok) begin
        r_addr  <= r_addr + 1'b1;
        r_words <= r_words + 1'b1;
      end else begin
        r_err <= ERR_OPCODE;
      end
    end
  end

  assign imem_addr    = r_addr;
  assign imem_wdata   = r_wdata;
  assign busy         = (r_state == ST_LOAD) || (r_state == ST_WRITE);
  assign done         = (r_state == ST_DONE);
  assign err          = r_err;
  assign words_loaded = r_words;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] r_checksum;

  // Running XOR of every word actually written this session
  always_ff @(posedge clk) begin
    if (rst)             r_checksum <= '0;
    else if (w_start_ok) r_checksum <= '0;
    else if (imem_we)    r_checksum <= r_checksum ^ r_wdata;
  end

  assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader. Two instances share stimulus:
// ADDR_W=8 for the functional cases, ADDR_W=2 for the overflow case.
// Checksum checks are compiled in with IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_last;
  logic [7:0]  in_data;

  logic        in_ready, imem_we, busy, done;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [1:0]  err;
  logic [8:0]  words_loaded;

  logic        s_in_ready, s_we, s_busy, s_done;
  logic [1:0]  s_addr;
  logic [31:0] s_wdata;
  logic [1:0]  s_err;
  logic [2:0]  s_words;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] checksum, s_checksum;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int we_cnt   = 0;
  int s_we_cnt = 0;
  int base;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
`ifdef IMEM_LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  imem_loader #(.ADDR_W(2)) dut_small (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(s_in_ready),
    .imem_we(s_we), .imem_addr(s_addr), .imem_wdata(s_wdata),
    .busy(s_busy), .done(s_done), .err(s_err), .words_loaded(s_words)
`ifdef IMEM_LOADER_CHECKSUM_EN
    , .checksum(s_checksum)
`endif
  );

  // Count write strobes seen at each active edge
  always @(posedge clk) begin
    if (imem_we) we_cnt++;
    if (s_we)    s_we_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled on the falling edge
  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Four bytes MSB first; in_last only on the 4th when requested
  task automatic send_word(input logic [31:0] w, input logic last, input logic hit_start);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = w[31-8*i -: 8];
      in_last  = last && (i == 3);
      start    = hit_start && (i == 0);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
    start    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    step();
    step();
    rst = 1'b0;
    step();

    // Reset state
    check("rst_in_ready", in_ready, 0);
    check("rst_we", imem_we, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_words", words_loaded, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("rst_csum", checksum, 0);
`endif

    // Single lw word terminated by in_last
    pulse_start();
    check("t1_busy", busy, 1);
    check("t1_ready", in_ready, 1);
    send_word(32'h8C020004, 1'b1, 1'b0);
    check("t1_we", imem_we, 1);
    check("t1_addr", imem_addr, 0);
    check("t1_wdata", imem_wdata, 32'h8C020004);
    check("t1_ready_wr", in_ready, 0);
    step();
    check("t1_done", done, 1);
    check("t1_busy_end", busy, 0);
    check("t1_words", words_loaded, 1);
    check("t1_err", err, 0);

    // Three words back-to-back, 5 cycles each; a start on word 2 must be ignored
    pulse_start();
    check("t2_done_clr", done, 0);
    send_word(32'h20010005, 1'b0, 1'b0);
    check("t2_we0", imem_we, 1);
    check("t2_addr0", imem_addr, 0);
    check("t2_ready0", in_ready, 0);
    step();
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("t2_csum1", checksum, 32'h20010005);
`endif
    send_word(32'h00221820, 1'b0, 1'b1);
    check("t2_we1", imem_we, 1);
    check("t2_addr1", imem_addr, 1);
    check("t2_wdata1", imem_wdata, 32'h00221820);
    check("t2_ready1", in_ready, 0);
    step();
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("t2_csum2", checksum, 32'h20231825);
`endif
    send_word(32'h08000000, 1'b1, 1'b0);
    check("t2_we2", imem_we, 1);
    check("t2_addr2", imem_addr, 2);
    check("t2_wdata2", imem_wdata, 32'h08000000);
    step();
    check("t2_done", done, 1);
    check("t2_words", words_loaded, 3);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("t2_csum3", checksum, 32'h28231825);
`endif

    // Unsupported opcode 111111: no write, err=1 until next start
    pulse_start();
    base = we_cnt;
    send_word(32'hFC000000, 1'b1, 1'b0);
    check("t3_we", imem_we, 0);
    step();
    check("t3_err", err, 1);
    check("t3_busy", busy, 0);
    check("t3_done", done, 0);
    check("t3_nowrite", we_cnt - base, 0);
    pulse_start();
    check("t3_err_clr", err, 0);
    check("t3_busy2", busy, 1);

    // in_last on the 2nd byte: misaligned end, nothing written
    base = we_cnt;
    in_valid = 1'b1; in_data = 8'h20; in_last = 1'b0;
    step();
    in_data = 8'h01; in_last = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    check("t4_err", err, 2);
    check("t4_busy", busy, 0);
    check("t4_words", words_loaded, 0);
    step();
    check("t4_nowrite", we_cnt - base, 0);

    // ADDR_W=2: four words fill memory, the fifth overflows
    pulse_start();
    base = s_we_cnt;
    for (int k = 0; k < 4; k++) begin
      send_word(32'h20010005 + 32'(k), 1'b0, 1'b0);
      check($sformatf("t5_we%0d", k), s_we, 1);
      check($sformatf("t5_addr%0d", k), s_addr, k);
      step();
    end
    send_word(32'h20010009, 1'b0, 1'b0);
    check("t5_err", s_err, 3);
    check("t5_we_ovf", s_we, 0);
    check("t5_words", s_words, 4);
    check("t5_busy", s_busy, 0);
    step();
    check("t5_wr_count", s_we_cnt - base, 4);

    // Reset mid-word, then a clean session writes at address 0
    pulse_start();
    in_valid = 1'b1; in_data = 8'h20;
    step();
    in_data = 8'h01;
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_busy_rst", busy, 0);
    check("t6_ready_rst", in_ready, 0);
    check("t6_words_rst", words_loaded, 0);
    check("t6_err_rst", err, 0);
    pulse_start();
    send_word(32'h20010005, 1'b1, 1'b0);
    check("t6_we", imem_we, 1);
    check("t6_addr", imem_addr, 0);
    check("t6_wdata", imem_wdata, 32'h20010005);
    step();
    check("t6_done", done, 1);
    check("t6_words", words_loaded, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("t6_csum", checksum, 32'h20010005);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
